// File: rtl/rv32_alu_arbiter.sv
// rv32_alu_arbiter: shares one combinational rv32_alu between two requesters through one issue stage
// and a one-entry response slot per requester. Define ALU_ARB_FIXED_PRIO_EN for fixed req0 priority.
module rv32_alu_arbiter #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             req0_valid_in,
    output logic             req0_ready_out,
    input  logic [31:0]      req0_op1_in,
    input  logic [31:0]      req0_op2_in,
    input  logic [3:0]       req0_opcode_in,
    input  logic [TAG_W-1:0] req0_tag_in,
    input  logic             req1_valid_in,
    output logic             req1_ready_out,
    input  logic [31:0]      req1_op1_in,
    input  logic [31:0]      req1_op2_in,
    input  logic [3:0]       req1_opcode_in,
    input  logic [TAG_W-1:0] req1_tag_in,
    output logic             rsp0_valid_out,
    input  logic             rsp0_ready_in,
    output logic [31:0]      rsp0_result_out,
    output logic [TAG_W-1:0] rsp0_tag_out,
    output logic             rsp1_valid_out,
    input  logic             rsp1_ready_in,
    output logic [31:0]      rsp1_result_out,
    output logic [TAG_W-1:0] rsp1_tag_out,
    output logic [31:0]      alu_op_1_out,
    output logic [31:0]      alu_op_2_out,
    output logic [3:0]       alu_opcode_out,
    input  logic [31:0]      alu_result_in
);

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_BUSY  = 2'd1,
        SLOT_FULL  = 2'd2
    } slot_e;

    slot_e            slot_q [2];
    slot_e            slot_d [2];

    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0]       elig;
    logic [1:0]       prio;
    logic [1:0]       ready;
    logic [1:0]       accept;
    logic [1:0]       rsp_valid;

    logic             issue_valid_q;
    logic             issue_valid_d;
    logic             issue_owner_q;
    logic             issue_owner_d;
    logic [31:0]      issue_op1_q;
    logic [31:0]      issue_op1_d;
    logic [31:0]      issue_op2_q;
    logic [31:0]      issue_op2_d;
    logic [3:0]       issue_opcode_q;
    logic [3:0]       issue_opcode_d;
    logic [TAG_W-1:0] issue_tag_q;
    logic [TAG_W-1:0] issue_tag_d;

    logic [31:0]      rsp_result_q [2];
    logic [31:0]      rsp_result_d [2];
    logic [TAG_W-1:0] rsp_tag_q [2];
    logic [TAG_W-1:0] rsp_tag_d [2];

    assign req_valid = {req1_valid_in, req0_valid_in};
    assign rsp_ready = {rsp1_ready_in, rsp0_ready_in};

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign prio = 2'b01;
`else
    logic last_grant_q;
    logic last_grant_d;

    // prio[n] set: requester n wins a conflict because the other one was granted last
    assign prio = {~last_grant_q, last_grant_q};

    always_comb begin
        last_grant_d = last_grant_q;
        if (|accept) begin
            last_grant_d = accept[1];
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Slot FSM: state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < 2; i++) begin
                slot_q[i] <= SLOT_EMPTY;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // Slot FSM: next state
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            slot_d[i] = slot_q[i];
            case (slot_q[i])
                SLOT_EMPTY: if (accept[i]) slot_d[i] = SLOT_BUSY;
                SLOT_BUSY:  slot_d[i] = SLOT_FULL;
                SLOT_FULL:  if (rsp_ready[i]) slot_d[i] = SLOT_EMPTY;
                default:    slot_d[i] = SLOT_EMPTY;
            endcase
        end
    end

    // Slot FSM: outputs and grant; ready is held low while reset is asserted
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            elig[i]      = req_valid[i] & (slot_q[i] == SLOT_EMPTY);
            rsp_valid[i] = (slot_q[i] == SLOT_FULL);
        end
        ready[0] = rst_n_in & (slot_q[0] == SLOT_EMPTY) & (~elig[1] | prio[0]);
        ready[1] = rst_n_in & (slot_q[1] == SLOT_EMPTY) & (~elig[0] | prio[1]);
        accept   = req_valid & ready;
    end

    always_comb begin
        issue_valid_d  = |accept;
        issue_owner_d  = issue_owner_q;
        issue_op1_d    = issue_op1_q;
        issue_op2_d    = issue_op2_q;
        issue_opcode_d = issue_opcode_q;
        issue_tag_d    = issue_tag_q;
        if (accept[1]) begin
            issue_owner_d  = 1'b1;
            issue_op1_d    = req1_op1_in;
            issue_op2_d    = req1_op2_in;
            issue_opcode_d = req1_opcode_in;
            issue_tag_d    = req1_tag_in;
        end else if (accept[0]) begin
            issue_owner_d  = 1'b0;
            issue_op1_d    = req0_op1_in;
            issue_op2_d    = req0_op2_in;
            issue_opcode_d = req0_opcode_in;
            issue_tag_d    = req0_tag_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            issue_valid_q  <= 1'b0;
            issue_owner_q  <= 1'b0;
            issue_op1_q    <= '0;
            issue_op2_q    <= '0;
            issue_opcode_q <= '0;
            issue_tag_q    <= '0;
        end else begin
            issue_valid_q  <= issue_valid_d;
            issue_owner_q  <= issue_owner_d;
            issue_op1_q    <= issue_op1_d;
            issue_op2_q    <= issue_op2_d;
            issue_opcode_q <= issue_opcode_d;
            issue_tag_q    <= issue_tag_d;
        end
    end

    // Only the owner's slot is BUSY, so a FULL slot is never overwritten here
    always_comb begin
        for (int unsigned i = 0; i < 2; i++) begin
            rsp_result_d[i] = rsp_result_q[i];
            rsp_tag_d[i]    = rsp_tag_q[i];
            if (issue_valid_q && (issue_owner_q == i[0])) begin
                rsp_result_d[i] = alu_result_in;
                rsp_tag_d[i]    = issue_tag_q;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int unsigned i = 0; i < 2; i++) begin
                rsp_result_q[i] <= '0;
                rsp_tag_q[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                rsp_result_q[i] <= rsp_result_d[i];
                rsp_tag_q[i]    <= rsp_tag_d[i];
            end
        end
    end

    assign req0_ready_out  = ready[0];
    assign req1_ready_out  = ready[1];
    assign rsp0_valid_out  = rsp_valid[0];
    assign rsp1_valid_out  = rsp_valid[1];
    assign rsp0_result_out = rsp_result_q[0];
    assign rsp1_result_out = rsp_result_q[1];
    assign rsp0_tag_out    = rsp_tag_q[0];
    assign rsp1_tag_out    = rsp_tag_q[1];
    assign alu_op_1_out    = issue_op1_q;
    assign alu_op_2_out    = issue_op2_q;
    assign alu_opcode_out  = issue_opcode_q;

endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// tb_rv32_alu_arbiter: directed and random stimulus for rv32_alu_arbiter, with a combinational ALU
// stand-in and a transaction-level model of grant order, latency and response contents.
module tb_rv32_alu_arbiter;

    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             req_valid [2];
    logic             req_ready [2];
    logic [31:0]      req_op1 [2];
    logic [31:0]      req_op2 [2];
    logic [3:0]       req_opc [2];
    logic [TAG_W-1:0] req_tag [2];
    logic             rsp_valid [2];
    logic             rsp_ready [2];
    logic [31:0]      rsp_res [2];
    logic [TAG_W-1:0] rsp_tag [2];
    logic [31:0]      alu_op1;
    logic [31:0]      alu_op2;
    logic [3:0]       alu_opc;
    logic [31:0]      alu_res;

    int checks = 0;
    int failures = 0;

    // Model state: one outstanding op per requester, plus grant history
    bit               out_q [2];
    int               acc_cyc [2];
    logic [31:0]      exp_res [2];
    logic [TAG_W-1:0] exp_tag [2];
    bit               pend [2];
    bit               lg;
    logic [TAG_W-1:0] tag_ctr [2];
    int               grant_log [$];
    int               cyc;
    bit               iss_v;
    logic [31:0]      iss_op1;
    logic [31:0]      iss_op2;
    logic [3:0]       iss_opc;
    logic [31:0]      last_rsp_res [2];

    rv32_alu_arbiter #(.TAG_W(TAG_W)) dut (
        .clk_in          (clk),
        .rst_n_in        (rst_n),
        .req0_valid_in   (req_valid[0]),
        .req0_ready_out  (req_ready[0]),
        .req0_op1_in     (req_op1[0]),
        .req0_op2_in     (req_op2[0]),
        .req0_opcode_in  (req_opc[0]),
        .req0_tag_in     (req_tag[0]),
        .req1_valid_in   (req_valid[1]),
        .req1_ready_out  (req_ready[1]),
        .req1_op1_in     (req_op1[1]),
        .req1_op2_in     (req_op2[1]),
        .req1_opcode_in  (req_opc[1]),
        .req1_tag_in     (req_tag[1]),
        .rsp0_valid_out  (rsp_valid[0]),
        .rsp0_ready_in   (rsp_ready[0]),
        .rsp0_result_out (rsp_res[0]),
        .rsp0_tag_out    (rsp_tag[0]),
        .rsp1_valid_out  (rsp_valid[1]),
        .rsp1_ready_in   (rsp_ready[1]),
        .rsp1_result_out (rsp_res[1]),
        .rsp1_tag_out    (rsp_tag[1]),
        .alu_op_1_out    (alu_op1),
        .alu_op_2_out    (alu_op2),
        .alu_opcode_out  (alu_opc),
        .alu_result_in   (alu_res)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a << b[4:0];
            4'b0010: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: return (a < b) ? 32'd1 : 32'd0;
            4'b0100: return a ^ b;
            4'b0101: return a >> b[4:0];
            4'b1101: return $unsigned($signed(a) >>> b[4:0]);
            4'b0110: return a | b;
            4'b0111: return a & b;
            default: return {28'hBAD0000, op} ^ a;
        endcase
    endfunction

    always_comb alu_res = alu_ref(alu_op1, alu_op2, alu_opc);

    // Conflict winner: round-robin against the last grant, or req0 always in the fixed build
    function automatic bit wins(input int i);
`ifdef ALU_ARB_FIXED_PRIO_EN
        return i == 0;
`else
        return i != int'(lg);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", name, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid[0] = 1'b1;
        req_valid[1] = 1'b1;
        #1;
        check("rst_ready0", 32'(req_ready[0]), 32'd0);
        check("rst_ready1", 32'(req_ready[1]), 32'd0);
        check("rst_rsp0_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_rsp1_valid", 32'(rsp_valid[1]), 32'd0);
        check("rst_rsp0_result", rsp_res[0], 32'd0);
        check("rst_rsp1_result", rsp_res[1], 32'd0);
        check("rst_rsp0_tag", 32'(rsp_tag[0]), 32'd0);
        check("rst_rsp1_tag", 32'(rsp_tag[1]), 32'd0);
        check("rst_alu_op1", alu_op1, 32'd0);
        check("rst_alu_op2", alu_op2, 32'd0);
        check("rst_alu_opcode", 32'(alu_opc), 32'd0);
        for (int i = 0; i < 2; i++) begin
            pend[i]      = 1'b0;
            out_q[i]     = 1'b0;
            req_valid[i] = 1'b0;
            rsp_ready[i] = 1'b0;
        end
        lg    = 1'b1;
        iss_v = 1'b0;
        cyc   = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, input logic [TAG_W-1:0] t);
        pend[i]      = 1'b1;
        req_valid[i] = 1'b1;
        req_op1[i]   = a;
        req_op2[i]   = b;
        req_opc[i]   = op;
        req_tag[i]   = t;
    endtask

    // One iteration per clock: drive after the edge, check at the falling edge, update model at the edge
    task automatic run(input int n, input int unsigned pv, input int unsigned pr0, input int unsigned pr1);
        bit exp_rdy [2];
        bit elig_m [2];
        bit acc [2];
        bit drain [2];
        bit exp_v;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(99) < pv)) begin
                    pend[i]    = 1'b1;
                    req_op1[i] = $urandom;
                    req_op2[i] = $urandom;
                    req_opc[i] = 4'($urandom_range(15));
                    req_tag[i] = tag_ctr[i];
                    tag_ctr[i] = tag_ctr[i] + TAG_W'(1);
                end
                req_valid[i] = pend[i];
            end
            rsp_ready[0] = ($urandom_range(99) < pr0);
            rsp_ready[1] = ($urandom_range(99) < pr1);
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                elig_m[i] = pend[i] && !out_q[i];
            end
            for (int i = 0; i < 2; i++) begin
                exp_rdy[i] = !out_q[i] && (!elig_m[1-i] || wins(i));
                exp_v      = out_q[i] && (cyc >= acc_cyc[i] + 2);
                check($sformatf("ready%0d_c%0d", i, cyc), 32'(req_ready[i]), 32'(exp_rdy[i]));
                check($sformatf("rsp%0d_valid_c%0d", i, cyc), 32'(rsp_valid[i]), 32'(exp_v));
                acc[i]   = elig_m[i] && exp_rdy[i];
                drain[i] = exp_v && rsp_ready[i];
                if (drain[i]) begin
                    check($sformatf("rsp%0d_result_c%0d", i, cyc), rsp_res[i], exp_res[i]);
                    check($sformatf("rsp%0d_tag_c%0d", i, cyc), 32'(rsp_tag[i]), 32'(exp_tag[i]));
                    last_rsp_res[i] = rsp_res[i];
                end
            end
            if (iss_v) begin
                check($sformatf("alu_op1_c%0d", cyc), alu_op1, iss_op1);
                check($sformatf("alu_op2_c%0d", cyc), alu_op2, iss_op2);
                check($sformatf("alu_opcode_c%0d", cyc), 32'(alu_opc), 32'(iss_opc));
            end
            @(posedge clk);
            iss_v = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (drain[i]) out_q[i] = 1'b0;
                if (acc[i]) begin
                    out_q[i]   = 1'b1;
                    acc_cyc[i] = cyc;
                    pend[i]    = 1'b0;
                    lg         = (i == 1);
                    grant_log.push_back(i);
                    exp_res[i] = alu_ref(req_op1[i], req_op2[i], req_opc[i]);
                    exp_tag[i] = req_tag[i];
                    iss_v      = 1'b1;
                    iss_op1    = req_op1[i];
                    iss_op2    = req_op2[i];
                    iss_opc    = req_opc[i];
                end
            end
            cyc++;
            #1;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            req_valid[i]    = 1'b0;
            req_op1[i]      = '0;
            req_op2[i]      = '0;
            req_opc[i]      = '0;
            req_tag[i]      = '0;
            rsp_ready[i]    = 1'b0;
            tag_ctr[i]      = '0;
            last_rsp_res[i] = '1;
        end

        // Single ADD: ready in cycle 0, ALU driven in cycle 1, response in cycle 2
        do_reset();
        load(0, 32'd15, 32'd10, 4'b0000, 4'd3);
        #1;
        check("t1_ready0_c0", 32'(req_ready[0]), 32'd1);
        run(1, 0, 100, 100);
        check("t1_alu_opcode_c1", 32'(alu_opc), 32'd0);
        check("t1_rsp0_valid_c1", 32'(rsp_valid[0]), 32'd0);
        run(1, 0, 100, 100);
        check("t1_rsp0_valid_c2", 32'(rsp_valid[0]), 32'd1);
        check("t1_rsp0_result", rsp_res[0], 32'd25);
        check("t1_rsp0_tag", 32'(rsp_tag[0]), 32'd3);
        run(2, 0, 100, 100);

        // Conflict straight after reset: req0 first, req1 next cycle
        do_reset();
        load(0, 32'd15, 32'd10, 4'b1000, 4'd1);
        load(1, 32'hFFFF_FFF8, 32'd2, 4'b1101, 4'd2);
        #1;
        check("t2_ready0_c0", 32'(req_ready[0]), 32'd1);
        check("t2_ready1_c0", 32'(req_ready[1]), 32'd0);
        run(1, 0, 100, 100);
        check("t2_alu_opcode_c1", 32'(alu_opc), 32'b1000);
        check("t2_ready1_c1", 32'(req_ready[1]), 32'd1);
        run(1, 0, 100, 100);
        check("t2_rsp0_valid", 32'(rsp_valid[0]), 32'd1);
        check("t2_rsp0_result", rsp_res[0], 32'd5);
        check("t2_alu_opcode_c2", 32'(alu_opc), 32'b1101);
        run(1, 0, 100, 100);
        check("t2_rsp1_valid", 32'(rsp_valid[1]), 32'd1);
        check("t2_rsp1_result", rsp_res[1], 32'hFFFF_FFFE);
        check("t2_rsp1_tag", 32'(rsp_tag[1]), 32'd2);
        run(1, 0, 100, 100);

        // Backpressure on rsp0 while req1 keeps being served
        load(0, 32'd1, 32'd2, 4'b0000, 4'd5);
        run(2, 0, 0, 100);
        load(0, 32'd7, 32'd8, 4'b0000, 4'd9);
        load(1, 32'd5, 32'd10, 4'b0011, 4'd6);
        for (int k = 0; k < 10; k++) begin
            check("t3_rsp0_valid_hold", 32'(rsp_valid[0]), 32'd1);
            check("t3_rsp0_result_hold", rsp_res[0], 32'd3);
            check("t3_rsp0_tag_hold", 32'(rsp_tag[0]), 32'd5);
            check("t3_ready0_blocked", 32'(req_ready[0]), 32'd0);
            run(1, 0, 0, 100);
        end
        check("t3_rsp1_sltu", last_rsp_res[1], 32'd1);
        run(6, 0, 100, 100);

        // Both requesters continuously valid: grants alternate starting with req0
        do_reset();
        grant_log.delete();
        run(12, 100, 100, 100);
        check("t4_grant_count", 32'(grant_log.size() >= 8), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t4_grant%0d", k),
                  32'((k < grant_log.size()) ? grant_log[k] : -1), 32'(k % 2));
        end
        run(6, 0, 100, 100);

        // Reset while slot0 is BUSY drops the in-flight op
        load(0, 32'd100, 32'd23, 4'b0000, 4'd7);
        run(1, 0, 100, 100);
        do_reset();
        run(4, 0, 100, 100);
        check("t5_no_stale_rsp0", 32'(rsp_valid[0]), 32'd0);

        // Random traffic with random backpressure, including undefined opcodes
        do_reset();
        run(800, 55, 70, 70);
        run(8, 0, 100, 100);
        check("rand_drained_rsp0", 32'(rsp_valid[0]), 32'd0);
        check("rand_drained_rsp1", 32'(rsp_valid[1]), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
